sdram_region_loader: RTL and testbench

- Generalised boot-time loader. Streams consecutive DATA_W-bit words from SDRAM into up to NUM_REGIONS on-chip memories, one write strobe per region.
- Region lengths and source base are runtime inputs, sampled at start. Supports re-load on demand and flags SDRAM read timeouts.
- Sits between the SDRAM read controller and the sprite/palette on-chip RAMs. Its done output gates the renderer.

---
 rtl/sdram_region_loader.sv | 181 ++++++++++++++++++
 tb/tb_sdram_region_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_region_loader.sv
// rtl/sdram_region_loader.sv - streams SDRAM words into up to NUM_REGIONS on-chip RAMs with read timeout
// Optional running lane checksum on csum when MEM_LOADER_CSUM_EN is defined.
module sdram_region_loader #(
  parameter int                  DATA_W      = 128,
  parameter int                  SDRAM_AW    = 22,
  parameter int                  MEM_AW      = 9,
  parameter int                  NUM_REGIONS = 4,
  parameter logic [SDRAM_AW-1:0] DEF_BASE    = 'h31E000,
  parameter bit                  AUTO_START  = 1'b1,
  parameter int                  TIMEOUT     = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SDRAM_AW-1:0]           src_base,
  input  logic [NUM_REGIONS*(MEM_AW+1)-1:0] region_len,
  input  logic                          sdram_wait,
  input  logic                          sdram_ac,
  input  logic [DATA_W-1:0]             sdram_data,
  output logic                          sdram_rd,
  output logic [SDRAM_AW-1:0]           sdram_addr,
  output logic [DATA_W-1:0]             mem_data,
  output logic [MEM_AW-1:0]             mem_addr,
  output logic [NUM_REGIONS-1:0]        mem_wr,
  output logic [2:0]                    cur_region,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   csum
);

  localparam int LW = MEM_AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(1) << MEM_AW;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, READ, WRITE, NEXT_REG, DONE, ERROR} state_t;

  state_t                         state_q, state_d;
  logic [NUM_REGIONS-1:0][LW-1:0] len_q, len_d, len_in;
  logic [RW-1:0]                  cur_q, cur_d, first_nz, next_nz;
  logic                           next_found;
  logic [MEM_AW-1:0]              mem_addr_q, mem_addr_d;
  logic [SDRAM_AW-1:0]            sdram_addr_q, sdram_addr_d;
  logic [DATA_W-1:0]              mem_data_q, mem_data_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic                           auto_q;
  logic                           load_go;

  // Auto-start is a one-shot pending start that fires on the first cycle out of reset.
  assign load_go = ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR)) &&
                   (start || auto_q);

  // Clamp incoming lengths and find the first / next non-empty region (lowest index wins).
  always_comb begin
    len_in     = '0;
    first_nz   = '0;
    next_nz    = '0;
    next_found = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      len_in[i] = (region_len[i*LW +: LW] > LEN_MAX) ? LEN_MAX : region_len[i*LW +: LW];
      if (len_in[i] != '0) first_nz = RW'(i);
      if ((len_q[i] != '0) && (RW'(i) > cur_q)) begin
        next_nz    = RW'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cur_d        = cur_q;
    mem_addr_d   = mem_addr_q;
    sdram_addr_d = sdram_addr_q;
    mem_data_d   = mem_data_q;
    tmo_d        = tmo_q;
    if (load_go) begin
      len_d        = len_in;
      cur_d        = first_nz;
      mem_addr_d   = '0;
      sdram_addr_d = auto_q ? DEF_BASE : src_base;
      state_d      = WAIT_RDY;
    end else begin
      case (state_q)
        WAIT_RDY: begin
          if (len_q == '0) begin
            state_d = DONE;
          end else if (!sdram_wait) begin
            tmo_d   = '0;
            state_d = READ;
          end
        end
        READ: begin
          if (sdram_ac) begin
            mem_data_d = sdram_data;
            state_d    = WRITE;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ERROR;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        WRITE: begin
          sdram_addr_d = sdram_addr_q + SDRAM_AW'(1);
          if ({1'b0, mem_addr_q} == len_q[cur_q] - LW'(1)) begin
            state_d = NEXT_REG;
          end else begin
            mem_addr_d = mem_addr_q + MEM_AW'(1);
            state_d    = WAIT_RDY;
          end
        end
        NEXT_REG: begin
          mem_addr_d = '0;
          if (next_found) begin
            cur_d   = next_nz;
            state_d = WAIT_RDY;
          end else begin
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cur_q        <= '0;
      mem_addr_q   <= '0;
      sdram_addr_q <= DEF_BASE;
      mem_data_q   <= '0;
      tmo_q        <= '0;
      auto_q       <= AUTO_START;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cur_q        <= cur_d;
      mem_addr_q   <= mem_addr_d;
      sdram_addr_q <= sdram_addr_d;
      mem_data_q   <= mem_data_d;
      tmo_q        <= tmo_d;
      auto_q       <= 1'b0;
    end
  end

`ifdef MEM_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d, lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < DATA_W / 32; i++) lane_sum = lane_sum + mem_data_q[i*32 +: 32];
    csum_d = csum_q;
    if (load_go)                csum_d = '0;
    else if (state_q == WRITE)  csum_d = csum_q + lane_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

  assign sdram_rd   = (state_q == READ);
  assign sdram_addr = sdram_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = (state_q == WRITE) ? (NUM_REGIONS'(1) << cur_q) : '0;
  assign cur_region = 3'(cur_q);
  assign busy       = (state_q == WAIT_RDY) || (state_q == READ) ||
                      (state_q == WRITE) || (state_q == NEXT_REG);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_sdram_region_loader.sv
// tb/tb_sdram_region_loader.sv - scoreboard bench for sdram_region_loader
// Load vectors from a table plus hand sequences for stall, timeout, ignored start and reset abort.
module tb_sdram_region_loader;

  localparam logic [21:0] DEF_BASE = 22'h31E000;

  logic         clk = 1'b0;
  logic         reset, start, sdram_wait, sdram_ac;
  logic [21:0]  src_base;
  logic [39:0]  region_len;
  logic [127:0] sdram_data;
  logic         sdram_rd, busy, done, err;
  logic [21:0]  sdram_addr;
  logic [127:0] mem_data;
  logic [8:0]   mem_addr;
  logic [3:0]   mem_wr;
  logic [2:0]   cur_region;
  logic [31:0]  csum;

  sdram_region_loader #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base), .region_len(region_len),
    .sdram_wait(sdram_wait), .sdram_ac(sdram_ac), .sdram_data(sdram_data),
    .sdram_rd(sdram_rd), .sdram_addr(sdram_addr), .mem_data(mem_data), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .cur_region(cur_region), .busy(busy), .done(done), .err(err), .csum(csum)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   wr;
    logic [8:0]   addr;
    logic [127:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [21:0] base;
    logic [39:0] lens;
    int          delay;
    bit          pat;
    logic [21:0] exp_addr;
  } vec_t;

  wr_t   exp_q[$];
  vec_t  vecs[6];
  int    checks = 0, fails = 0;
  int    writes_seen = 0, rd_cnt = 0, rd_hi = 0, ac_delay = 1;
  bit    ac_en = 1'b1, pat = 1'b0;
  logic [31:0] exp_sum;
  logic [21:0] end_addr;

  function automatic logic [127:0] data_of(input logic [21:0] a, input bit p);
    logic [31:0] x;
    x = {10'h0, a};
    if (p) return a[0] ? {4{32'hFFFF_FFFF}} : {4{32'h0000_0001}};
    return {~x, x ^ 32'hA5A5_0000, x * 32'd7 + 32'd3, x};
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: check any write against the scoreboard, then drive the SDRAM response model.
  task automatic tick();
    @(negedge clk);
    if (!reset && mem_wr != '0) begin
      writes_seen++;
      if (exp_q.size() == 0) chk("unexpected_write", {mem_wr, mem_addr, mem_data}, '0);
      else chk("write", {mem_wr, mem_addr, mem_data}, exp_q.pop_front());
    end
    if (sdram_rd) rd_hi++;
    sdram_ac   = sdram_rd && ac_en && (rd_cnt >= ac_delay);
    sdram_data = sdram_ac ? data_of(sdram_addr, pat) : '0;
    rd_cnt     = sdram_rd ? rd_cnt + 1 : 0;
  endtask

  task automatic push_load(input logic [21:0] base, input logic [39:0] lens,
                           output logic [21:0] last, output logic [31:0] sum);
    logic [21:0]  a;
    logic [127:0] d;
    int           l;
    wr_t          e;
    a   = base;
    sum = '0;
    for (int r = 0; r < 4; r++) begin
      l = int'(lens[r*10 +: 10]);
      if (l > 512) l = 512;
      for (int k = 0; k < l; k++) begin
        d      = data_of(a, pat);
        e.wr   = 4'b0001 << r;
        e.addr = 9'(k);
        e.data = d;
        exp_q.push_back(e);
        sum = sum + d[31:0] + d[63:32] + d[95:64] + d[127:96];
        a   = a + 22'd1;
      end
    end
    last = a;
`ifndef MEM_LOADER_CSUM_EN
    sum = '0;
`endif
  endtask

  task automatic start_load(input logic [21:0] base, input logic [39:0] lens);
    src_base   = base;
    region_len = lens;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_end(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk({name, "_finish_in_time"}, busy, 1'b0);
  endtask

  task automatic wait_writes(input string name, input int cnt, input int limit);
    int target = writes_seen + cnt;
    int n = 0;
    while (writes_seen < target && n < limit) begin
      tick();
      n++;
    end
    chk({name, "_writes_in_time"}, writes_seen >= target, 1'b1);
  endtask

  initial begin
    vecs[0] = '{"skip",   22'h000100, {10'd2, 10'd0, 10'd3, 10'd0},     0, 1'b0, 22'h000105};
    vecs[1] = '{"zero",   22'h000200, 40'd0,                             0, 1'b0, 22'h000200};
    vecs[2] = '{"clamp",  22'h3FFFFE, {10'd1, 10'd0, 10'd0, 10'h3FF},   2, 1'b0, 22'h0001FF};
    vecs[3] = '{"single", 22'h012345, {10'd0, 10'd1, 10'd0, 10'd0},     1, 1'b0, 22'h012346};
    vecs[4] = '{"all2",   22'h000010, {10'd2, 10'd2, 10'd2, 10'd2},     3, 1'b0, 22'h000018};
    vecs[5] = '{"csum0",  22'h000020, {10'd0, 10'd0, 10'd0, 10'd2},     0, 1'b1, 22'h000022};

    reset = 1'b1; start = 1'b0; sdram_wait = 1'b0; sdram_ac = 1'b0; sdram_data = '0;
    src_base = '0; region_len = {10'd0, 10'd0, 10'h1CF, 10'h048};
    repeat (3) tick();
    chk("rst_sdram_addr", sdram_addr, DEF_BASE);
    chk("rst_flags", {busy, done, err, sdram_rd}, 4'b0000);
    chk("rst_mem_wr", mem_wr, 4'b0000);
    chk("rst_mem", {mem_addr, cur_region, mem_data}, '0);
    chk("rst_csum", csum, 32'd0);

    // Auto-start after reset with ac one cycle after rd.
    ac_delay = 1;
    push_load(DEF_BASE, region_len, end_addr, exp_sum);
    reset = 1'b0;
    tick();
    chk("auto_busy", busy, 1'b1);
    wait_end("auto", 4000);
    chk("auto_done", {done, err}, 2'b10);
    chk("auto_addr", sdram_addr, 22'h31E217);
    chk("auto_csum", csum, exp_sum);
    chk("auto_all_written", exp_q.size(), 0);

    foreach (vecs[i]) begin
      ac_delay = vecs[i].delay;
      pat      = vecs[i].pat;
      push_load(vecs[i].base, vecs[i].lens, end_addr, exp_sum);
      start_load(vecs[i].base, vecs[i].lens);
      wait_end(vecs[i].name, 4000);
      chk({vecs[i].name, "_done"}, {done, err, busy}, 3'b100);
      chk({vecs[i].name, "_addr"}, sdram_addr, vecs[i].exp_addr);
      chk({vecs[i].name, "_csum"}, csum, exp_sum);
      chk({vecs[i].name, "_all_written"}, exp_q.size(), 0);
    end
    pat = 1'b0;

    // Stall for 20 cycles after word 5 of region 0.
    begin
      bit stall_bad = 1'b0;
      ac_delay = 0;
      push_load(22'h000400, {30'd0, 10'd12}, end_addr, exp_sum);
      start_load(22'h000400, {30'd0, 10'd12});
      wait_writes("stall", 5, 100);
      sdram_wait = 1'b1;
      repeat (20) begin
        tick();
        if (sdram_rd || mem_wr != '0) stall_bad = 1'b1;
      end
      chk("stall_quiet", stall_bad, 1'b0);
      sdram_wait = 1'b0;
      wait_end("stall", 200);
      chk("stall_done", done, 1'b1);
      chk("stall_addr", sdram_addr, 22'h00040C);
      chk("stall_all_written", exp_q.size(), 0);
    end

    // Timeout: ac never comes.
    begin
      int n = 0;
      ac_en = 1'b0;
      rd_hi = 0;
      start_load(22'h000500, {30'd0, 10'd4});
      while (!err && n < 200) begin
        tick();
        n++;
      end
      chk("tmo_rd_cycles", rd_hi, 15);
      chk("tmo_flags", {err, busy, done, sdram_rd}, 4'b1000);
      ac_en = 1'b1;
      push_load(22'h000500, {30'd0, 10'd4}, end_addr, exp_sum);
      start_load(22'h000500, {30'd0, 10'd4});
      wait_end("tmo_retry", 200);
      chk("tmo_retry_flags", {done, err}, 2'b10);
      chk("tmo_retry_addr", sdram_addr, 22'h000504);
    end

    // Start during a load is ignored; reset at word 20 aborts at once.
    ac_delay = 1;
    push_load(22'h000600, {30'd0, 10'd30}, end_addr, exp_sum);
    start_load(22'h000600, {30'd0, 10'd30});
    wait_writes("ign", 10, 200);
    start_load(22'h000700, {10'd5, 10'd5, 10'd5, 10'd5});
    region_len = {30'd0, 10'd30};
    wait_writes("ign2", 10, 200);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_flags", {busy, done, err, sdram_rd}, 4'b0000);
    chk("rst_mid_mem_wr", mem_wr, 4'b0000);
    chk("rst_mid_addr", sdram_addr, DEF_BASE);
    chk("rst_mid_mem", {mem_addr, mem_data}, '0);
    repeat (2) tick();
    exp_q.delete();
    region_len = {30'd0, 10'd3};
    push_load(DEF_BASE, region_len, end_addr, exp_sum);
    reset = 1'b0;
    tick();
    wait_end("reauto", 200);
    chk("reauto_done", {done, err}, 2'b10);
    chk("reauto_addr", sdram_addr, 22'h31E003);
    chk("reauto_all_written", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
